// File: rtl/case_7_div_pkg.sv
// ============================================================================
// case_7_div_pkg : shared state encoding and sizing for the case_7 divider
// Revision: 1.0
// ============================================================================
`default_nettype none

package case_7_div_pkg;

  localparam int DIVIDEND_WIDTH_DEF = 8;
  localparam int DIVISOR_WIDTH_DEF  = 5;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W   = cnt_width(DIVIDEND_WIDTH_DEF);
  localparam int LATENCY = DIVIDEND_WIDTH_DEF + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/case_7_div_abs.sv
// ============================================================================
// case_7_div_abs : combinational sign/magnitude split of a signed operand
// Revision: 1.0
// ============================================================================
`default_nettype none

module case_7_div_abs #(
  parameter int W = 8
) (
  input  logic [W-1:0] val_i,
  output logic [W-1:0] mag_o,
  output logic         sgn_o
);

  // The most negative value maps to 2^(W-1), which is exact as an unsigned magnitude.
  assign sgn_o = val_i[W-1];
  assign mag_o = sgn_o ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

`default_nettype wire

// File: rtl/case_7_sdiv_8s_5s_8_seq.sv
// ============================================================================
// case_7_sdiv_8s_5s_8_seq : sequential signed restoring divider, one bit/cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module case_7_sdiv_8s_5s_8_seq
  import case_7_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEF,
  parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_DEF
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      ce,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend0,
  input  logic [DIVISOR_WIDTH-1:0]  divisor0,
  output logic                      busy,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quot,
  output logic [DIVISOR_WIDTH-1:0]  remd
);

  localparam int N   = DIVIDEND_WIDTH;
  localparam int M   = DIVISOR_WIDTH;
  localparam int CW  = cnt_width(N);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   dvd_q, dvd_d;
  logic [M-1:0]   dsr_q, dsr_d;
  logic [M-1:0]   rem_q, rem_d;
  logic           sign_quot_q, sign_quot_d;
  logic           sign_rem_q, sign_rem_d;
  logic           div_zero_q, div_zero_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [M-1:0]   remd_q, remd_d;

  logic [N-1:0]   w_dvd_mag;
  logic           w_dvd_sgn;
  logic [M-1:0]   w_dsr_mag;
  logic           w_dsr_sgn;
  logic [M:0]     w_partial;
  logic [M:0]     w_diff;
  logic           w_ge;

  case_7_div_abs #(.W(N)) u_abs_dvd (
    .val_i (dividend0),
    .mag_o (w_dvd_mag),
    .sgn_o (w_dvd_sgn)
  );

  case_7_div_abs #(.W(M)) u_abs_dsr (
    .val_i (divisor0),
    .mag_o (w_dsr_mag),
    .sgn_o (w_dsr_sgn)
  );

  // The dividend register doubles as the quotient: MSBs shift out, quotient bits shift in.
  assign w_partial = {rem_q, dvd_q[N-1]};
  assign w_diff    = w_partial - {1'b0, dsr_q};
  assign w_ge      = (w_partial >= {1'b0, dsr_q});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    sign_quot_d = sign_quot_q;
    sign_rem_d  = sign_rem_q;
    div_zero_d  = div_zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quot_d      = quot_q;
    remd_d      = remd_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d       = w_dvd_mag;
          dsr_d       = w_dsr_mag;
          rem_d       = '0;
          sign_quot_d = w_dvd_sgn ^ w_dsr_sgn;
          sign_rem_d  = w_dvd_sgn;
          div_zero_d  = (divisor0 == '0);
          cnt_d       = CW'(N - 1);
          busy_d      = 1'b1;
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        // With a zero divisor every step subtracts nothing, leaving the low
        // dividend magnitude bits in the remainder.
        rem_d = w_ge ? w_diff[M-1:0] : w_partial[M-1:0];
        dvd_d = {dvd_q[N-2:0], w_ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        quot_d  = div_zero_q ? '1 : (sign_quot_q ? (~dvd_q + N'(1)) : dvd_q);
        remd_d  = sign_rem_q ? (~rem_q + M'(1)) : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      sign_quot_q <= 1'b0;
      sign_rem_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quot_q      <= '0;
      remd_q      <= '0;
    end else if (ce) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      sign_quot_q <= sign_quot_d;
      sign_rem_q  <= sign_rem_d;
      div_zero_q  <= div_zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quot_q      <= quot_d;
      remd_q      <= remd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign remd = remd_q;

endmodule

`default_nettype wire
